uart_fifo_buffer: RTL and testbench
===================================

// Module: uart_fifo_buffer
// PURPOSE
//   First-word-fall-through (FWFT) synchronous FIFO between the UART RX/TX byte
//   stages and the ALU command interface.
//   - RX instance: the UART receiver pushes bytes; the interface FSM pops the
//     opcode, operand A and operand B.
//   - TX instance: the interface FSM pushes ALU results; the UART transmitter
//     pops them.
//   - Flow control is empty/full only, plus sticky error flags for overflow
//     and underflow.
// PARAMETERS
//   NB_DATA   8   width of each stored word, in bits
//   NB_ADDR   4   address width; depth = 2**NB_ADDR words (16 by default)
// PORTS
//   i_clk              in   1          clock, rising edge
//   i_reset            in   1          synchronous reset, active-high
//   i_fifo_WR          in   1          push request; i_fifo_WDATA stored at the clock edge
//   i_fifo_WDATA       in   NB_DATA    data to push
//   i_fifo_RD          in   1          pop request; discards the current head word
//   o_fifo_RDATA       out  NB_DATA    head word (FWFT); valid whenever o_fifo_EMPTY=0
//   o_fifo_EMPTY       out  1          FIFO holds 0 words
//   o_fifo_FULL        out  1          FIFO holds 2**NB_ADDR words
//   o_fifo_COUNT       out  NB_ADDR+1  current occupancy, 0 .. 2**NB_ADDR
//   o_fifo_OVERFLOW    out  1          sticky: a push was refused because the FIFO was full
//   o_fifo_UNDERFLOW   out  1          sticky: a pop was refused because the FIFO was empty
// BEHAVIOUR
//   Reset (synchronous, i_reset=1 at a rising edge)
//   - wr_ptr=0, rd_ptr=0, COUNT=0.
//   - Outputs after reset: EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0.
//   - Storage array is not cleared. RDATA is don't-care while EMPTY=1.
//   - Reset overrides any WR/RD sampled in the same cycle.
//   - Reset mid-stream discards all contents.
//   Storage and pointers
//   - Storage: 2**NB_ADDR x NB_DATA register array.
//     Written at the clock edge; read asynchronously at rd_ptr.
//   - Pointers are NB_ADDR bits wide and wrap naturally: 2**NB_ADDR-1 -> 0.
//   - COUNT is a registered counter. EMPTY and FULL are registered, or decoded
//     from COUNT (EMPTY = COUNT==0, FULL = COUNT==2**NB_ADDR).
//     Either way they must update on the same edge as COUNT.
//   Acceptance rules, evaluated on the pre-edge state
//   - do_wr = WR & (~FULL | RD)
//   - do_rd = RD & ~EMPTY
//   - Full with WR and RD together: both are performed; COUNT stays at max.
//     The popped slot is the one overwritten; pointer order is preserved.
//   - Empty with WR and RD together: only the write is performed.
//     UNDERFLOW is set; COUNT becomes 1.
//   - WR & FULL & ~RD: write is dropped, memory is unchanged, OVERFLOW is set.
//   - RD & EMPTY: pointers are unchanged, UNDERFLOW is set.
//   Pointer and counter updates
//   - do_wr: mem[wr_ptr] <= WDATA, then wr_ptr++.
//   - do_rd: rd_ptr++.
//   - COUNT += do_wr - do_rd.
//   Latency
//   - A word pushed at edge N appears on RDATA, with EMPTY=0, immediately
//     after edge N (1-cycle write-to-read latency).
//   - A pop at edge N presents the next word (or EMPTY=1) after edge N.
//   - RDATA must be stable while RD=0; it depends only on rd_ptr and the
//     memory contents.
//   Sticky flags
//   - OVERFLOW and UNDERFLOW stay at 1 until the next reset.
//   - They have no effect on data flow.
//   Consumer handshake
//   - The consumer may hold RD=1 for consecutive cycles to pop one word per
//     clock (back-to-back opcode/A/B reads).
//   - RD held while EMPTY is harmless apart from setting UNDERFLOW.
// TESTING
//   T1 reset
//      Hold i_reset=1 for 2 cycles -> EMPTY=1, FULL=0, COUNT=0, both sticky flags=0.
//   T2 ordering
//      Push 0x03, 0x0A, 0x05 on consecutive cycles, then RD for 3 cycles
//      -> RDATA=0x03, 0x0A, 0x05 in order; EMPTY=1 after the third pop; COUNT returns to 0.
//   T3 fill, overflow, wrap
//      Push 0x00..0x0F (16 words) -> FULL=1, COUNT=16.
//      Push 0xFF -> dropped, OVERFLOW=1.
//      Pop 16 -> data 0x00..0x0F, EMPTY=1.
//      Push 0xAA -> RDATA=0xAA, with the pointers wrapped.
//   T4 simultaneous at full
//      FIFO full of 0x00..0x0F; WR=1 with 0x55 and RD=1 in the same cycle
//      -> COUNT stays 16, head becomes 0x01, and 0x55 is the last word popped.
//   T5 simultaneous at empty / underflow
//      Empty FIFO; WR=1 with 0x77 and RD=1 together
//      -> COUNT=1, RDATA=0x77, UNDERFLOW=1.
//   T6 reset mid-stream
//      With 5 words queued, assert i_reset for 1 cycle -> EMPTY=1, COUNT=0.
//      A new push of 0x12 reads back as 0x12.

Source files
------------

// File: rtl/uart_fifo_buffer_if.sv
// Handshake bundle for uart_fifo_buffer: push/pop requests, head data and status.
// Signal names keep the original port names of the flat module.
interface uart_fifo_buffer_if #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
);
  logic               i_fifo_WR;
  logic [NB_DATA-1:0] i_fifo_WDATA;
  logic               i_fifo_RD;
  logic [NB_DATA-1:0] o_fifo_RDATA;
  logic               o_fifo_EMPTY;
  logic               o_fifo_FULL;
  logic [NB_ADDR:0]   o_fifo_COUNT;
  logic               o_fifo_OVERFLOW;
  logic               o_fifo_UNDERFLOW;

  // Producer/consumer side
  modport master (
    output i_fifo_WR, i_fifo_WDATA, i_fifo_RD,
    input  o_fifo_RDATA, o_fifo_EMPTY, o_fifo_FULL, o_fifo_COUNT,
           o_fifo_OVERFLOW, o_fifo_UNDERFLOW
  );

  // FIFO side
  modport slave (
    input  i_fifo_WR, i_fifo_WDATA, i_fifo_RD,
    output o_fifo_RDATA, o_fifo_EMPTY, o_fifo_FULL, o_fifo_COUNT,
           o_fifo_OVERFLOW, o_fifo_UNDERFLOW
  );
endinterface

// File: rtl/uart_fifo_buffer.sv
// First-word-fall-through synchronous FIFO between the UART byte stages and
// the ALU command interface. Empty/full flow control plus sticky
// overflow/underflow flags.
module uart_fifo_buffer #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  uart_fifo_buffer_if.slave  fifo
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0] COUNT_MAX = (NB_ADDR + 1)'(DEPTH);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               overflow;
  logic               underflow;
  logic               empty;
  logic               full;
  logic               do_wr;
  logic               do_rd;

  // Status decode and acceptance rules on the pre-edge state; a pop frees
  // the slot a simultaneous push at full will reuse.
  always_comb begin
    empty = (count == '0);
    full  = (count == COUNT_MAX);
    do_wr = fifo.i_fifo_WR & (~full | fifo.i_fifo_RD);
    do_rd = fifo.i_fifo_RD & ~empty;
  end

  // Storage write; not cleared by reset, but a push is not taken during reset
  always_ff @(posedge i_clk) begin
    if (do_wr && !i_reset) begin
      mem[wr_ptr] <= fifo.i_fifo_WDATA;
    end
  end

  // Pointers, occupancy counter and sticky error flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo.i_fifo_WR && full && !fifo.i_fifo_RD) overflow  <= 1'b1;
      if (fifo.i_fifo_RD && empty)                   underflow <= 1'b1;
    end
  end

  // Output drive: head word read asynchronously at rd_ptr
  always_comb begin
    fifo.o_fifo_RDATA     = mem[rd_ptr];
    fifo.o_fifo_EMPTY     = empty;
    fifo.o_fifo_FULL      = full;
    fifo.o_fifo_COUNT     = count;
    fifo.o_fifo_OVERFLOW  = overflow;
    fifo.o_fifo_UNDERFLOW = underflow;
  end

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// Directed self-checking bench for uart_fifo_buffer.
module tb_uart_fifo_buffer;

  localparam int NB_DATA = 8;
  localparam int NB_ADDR = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  uart_fifo_buffer_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  uart_fifo_buffer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .fifo    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request inputs; outputs sampled 1ns after the edge
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    bus.i_fifo_WR    = wr;
    bus.i_fifo_WDATA = wd;
    bus.i_fifo_RD    = rd;
    @(posedge clk);
    #1;
    bus.i_fifo_WR = 1'b0;
    bus.i_fifo_RD = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic fill_0_to_f();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_fifo_WR    = 1'b0;
    bus.i_fifo_WDATA = '0;
    bus.i_fifo_RD    = 1'b0;

    // T1 reset
    do_reset(2);
    check("t1_empty", 32'(bus.o_fifo_EMPTY), 1);
    check("t1_full",  32'(bus.o_fifo_FULL), 0);
    check("t1_count", 32'(bus.o_fifo_COUNT), 0);
    check("t1_ovf",   32'(bus.o_fifo_OVERFLOW), 0);
    check("t1_unf",   32'(bus.o_fifo_UNDERFLOW), 0);

    // T2 ordering
    step(1'b1, 8'h03, 1'b0);
    check("t2_head_latency", 32'(bus.o_fifo_RDATA), 32'h03);
    check("t2_nonempty", 32'(bus.o_fifo_EMPTY), 0);
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h05, 1'b0);
    check("t2_count3", 32'(bus.o_fifo_COUNT), 3);
    check("t2_head0", 32'(bus.o_fifo_RDATA), 32'h03);
    step(1'b0, 8'h00, 1'b1);
    check("t2_head1", 32'(bus.o_fifo_RDATA), 32'h0A);
    step(1'b0, 8'h00, 1'b1);
    check("t2_head2", 32'(bus.o_fifo_RDATA), 32'h05);
    step(1'b0, 8'h00, 1'b1);
    check("t2_empty", 32'(bus.o_fifo_EMPTY), 1);
    check("t2_count0", 32'(bus.o_fifo_COUNT), 0);
    check("t2_unf", 32'(bus.o_fifo_UNDERFLOW), 0);

    // T3 fill, overflow, wrap
    fill_0_to_f();
    check("t3_full", 32'(bus.o_fifo_FULL), 1);
    check("t3_count16", 32'(bus.o_fifo_COUNT), 16);
    check("t3_ovf_pre", 32'(bus.o_fifo_OVERFLOW), 0);
    step(1'b1, 8'hFF, 1'b0);
    check("t3_ovf", 32'(bus.o_fifo_OVERFLOW), 1);
    check("t3_count_hold", 32'(bus.o_fifo_COUNT), 16);
    check("t3_head_hold", 32'(bus.o_fifo_RDATA), 32'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_pop%0d", i), 32'(bus.o_fifo_RDATA), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    check("t3_empty", 32'(bus.o_fifo_EMPTY), 1);
    check("t3_ovf_sticky", 32'(bus.o_fifo_OVERFLOW), 1);
    step(1'b1, 8'hAA, 1'b0);
    check("t3_wrap_data", 32'(bus.o_fifo_RDATA), 32'hAA);
    check("t3_wrap_count", 32'(bus.o_fifo_COUNT), 1);
    step(1'b0, 8'h00, 1'b1);
    check("t3_wrap_empty", 32'(bus.o_fifo_EMPTY), 1);

    // T4 simultaneous push/pop at full
    do_reset(1);
    check("t4_ovf_cleared", 32'(bus.o_fifo_OVERFLOW), 0);
    fill_0_to_f();
    step(1'b1, 8'h55, 1'b1);
    check("t4_count16", 32'(bus.o_fifo_COUNT), 16);
    check("t4_full", 32'(bus.o_fifo_FULL), 1);
    check("t4_head01", 32'(bus.o_fifo_RDATA), 32'h01);
    check("t4_no_ovf", 32'(bus.o_fifo_OVERFLOW), 0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t4_pop%0d", i), 32'(bus.o_fifo_RDATA), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    check("t4_last55", 32'(bus.o_fifo_RDATA), 32'h55);
    check("t4_count1", 32'(bus.o_fifo_COUNT), 1);
    step(1'b0, 8'h00, 1'b1);
    check("t4_empty", 32'(bus.o_fifo_EMPTY), 1);
    check("t4_no_unf", 32'(bus.o_fifo_UNDERFLOW), 0);

    // T5 simultaneous push/pop at empty
    step(1'b1, 8'h77, 1'b1);
    check("t5_count1", 32'(bus.o_fifo_COUNT), 1);
    check("t5_data77", 32'(bus.o_fifo_RDATA), 32'h77);
    check("t5_unf", 32'(bus.o_fifo_UNDERFLOW), 1);
    check("t5_nonempty", 32'(bus.o_fifo_EMPTY), 0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("t5_rd_empty_count", 32'(bus.o_fifo_COUNT), 0);
    check("t5_unf_sticky", 32'(bus.o_fifo_UNDERFLOW), 1);

    // T6 reset mid-stream, with a push presented during reset
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    check("t6_count5", 32'(bus.o_fifo_COUNT), 5);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    check("t6_empty", 32'(bus.o_fifo_EMPTY), 1);
    check("t6_count0", 32'(bus.o_fifo_COUNT), 0);
    check("t6_unf_clr", 32'(bus.o_fifo_UNDERFLOW), 0);
    step(1'b1, 8'h12, 1'b0);
    check("t6_data12", 32'(bus.o_fifo_RDATA), 32'h12);
    check("t6_count1", 32'(bus.o_fifo_COUNT), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
